cw_sequencer: RTL and testbench
===============================

// Module: cw_sequencer
// PURPOSE
//  Consumer end of the decoder control-word interface. Fetches an instruction into
//  the instruction register, presents I/state/status to the opcode decoders, applies
//  the returned 33-bit control word to the datapath, and advances the micro-state via
//  its next_state field. Sits between the decoders and the datapath (ALU, regfile,
//  RAM, PC). Detects databus contention and halts on it.
// PARAMETERS
//  FETCH_PC_FS  2'b01  pc_fs driven during fetch (PC+4)
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  databus    in   64  shared bus; instruction fetched from databus[31:0]
//  cw_in      in   33  control word from the opcode-selected decoder
//  status_in  in   5   ALU status flags {V,C,N,Z,zero-detect}
//  I          out  32  instruction register, fed to decoders
//  state      out  2   execute micro-state, fed to decoders
//  status     out  5   status register, fed to decoders
//  alu_en,alu_bs,rf_b_en,rf_w,ram_en,ram_w,pc_en,pc_is  out 1 each  datapath controls
//  alu_fs     out  5   ALU function select
//  rf_sa,rf_sb,rf_da  out 5 each  regfile addresses
//  pc_fs      out  2   PC function select
//  fetch      out  1   high during fetch cycle
//  fault      out  1   sticky databus-contention flag
// BEHAVIOUR
//  cw_in fields: [32]alu_en [31]alu_bs [30:26]alu_fs [25]rf_b_en [24:20]rf_sa
//   [19:15]rf_sb [14:10]rf_da [9]rf_w [8]ram_en [7]ram_w [6]pc_en [5:4]pc_fs
//   [3]pc_is [2]status_ld [1:0]next_state.
//  Phases: FETCH, EXEC, HALT (2-bit register). Reset: phase=FETCH, I=0, state=0,
//   status=0, fault=0.
//  FETCH (1 cycle): outputs = ram_en=1, pc_fs=FETCH_PC_FS, fetch=1, all other
//   controls 0 (rf_sa/sb/da=31, alu_fs=5'b11111). Edge: I<=databus[31:0], state<=0,
//   phase<=EXEC. cw_in ignored.
//  EXEC: outputs are cw_in fields, combinationally (same cycle). Edge:
//   status<=status_in iff status_ld; if next_state==0 phase<=FETCH, state<=0;
//   else state<=next_state, stay EXEC. I holds.
//  Contention: in EXEC, count of {alu_en,rf_b_en,ram_en,pc_en} >1 -> rf_w, ram_w,
//   pc_fs (forced 00) suppressed and status not loaded that cycle; fault<=1,
//   phase<=HALT.
//  HALT: FETCH-idle outputs with ram_en=0, fetch=0; stays until reset. fault
//   stays 1.
//  Fetch-to-fetch latency: 1 + number of EXEC cycles (min 2 cycles/instruction).
//  No EXEC bound: a decoder returning next_state!=0 forever keeps sequencer in EXEC.
//  Reset mid-EXEC: all registers clear asynchronously; first cycle after release is
//   FETCH.
// TESTING
//  1. Reset release, databus=32'h94000005 -> cycle0 fetch=1,ram_en=1,pc_fs=01; cycle1
//     I=32'h94000005, state=0, controls=cw_in.
//  2. cw_in next_state=2'b01 then 2'b00 -> state sequence 0,1, then fetch=1 next cycle.
//  3. cw_in status_ld=1, status_in=5'b10101 -> status=5'b10101 after edge; with
//     status_ld=0 status holds.
//  4. cw_in alu_en=1,ram_en=1,rf_w=1 -> rf_w=0, pc_fs=00 that cycle, fault=1, HALT;
//     no further fetch.
//  5. Assert reset during state=1 of multi-cycle EXEC -> I=0,state=0,status=0,fault=0
//     immediately; FETCH after release.
//  6. Single-enable cw (pc_en only, rf_w=1, rf_da=30) -> passed through unchanged,
//     fault stays 0.

Source files
------------

// File: rtl/cw_sequencer.sv
// Fetch/execute sequencer: latches an instruction, applies the decoder's control word
// to the datapath and halts permanently if more than one unit tries to drive the databus.
module cw_sequencer #(
  parameter logic [1:0] FETCH_PC_FS = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] databus,
  input  logic [32:0] cw_in,
  input  logic [4:0]  status_in,
  output logic [31:0] I,
  output logic [1:0]  state,
  output logic [4:0]  status,
  output logic        alu_en,
  output logic        alu_bs,
  output logic [4:0]  alu_fs,
  output logic        rf_b_en,
  output logic [4:0]  rf_sa,
  output logic [4:0]  rf_sb,
  output logic [4:0]  rf_da,
  output logic        rf_w,
  output logic        ram_en,
  output logic        ram_w,
  output logic        pc_en,
  output logic [1:0]  pc_fs,
  output logic        pc_is,
  output logic        fetch,
  output logic        fault
);

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_HALT  = 2'd2
  } phase_t;

  phase_t      phase_q, phase_d;
  logic [31:0] i_q, i_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  status_q, status_d;
  logic        fault_q, fault_d;

  logic        cw_status_ld;
  logic [1:0]  cw_next_state;
  logic [2:0]  bus_drivers;
  logic        contention;
  logic        unused_databus_hi;

  assign cw_status_ld  = cw_in[2];
  assign cw_next_state = cw_in[1:0];
  // Only the instruction half of the bus is ever latched.
  assign unused_databus_hi = ^databus[63:32];

  assign bus_drivers = {2'b00, cw_in[32]} + {2'b00, cw_in[25]}
                     + {2'b00, cw_in[8]}  + {2'b00, cw_in[6]};
  assign contention  = (bus_drivers > 3'd1);

  always_comb begin
    phase_d  = phase_q;
    i_d      = i_q;
    state_d  = state_q;
    status_d = status_q;
    fault_d  = fault_q;

    alu_en  = 1'b0;
    alu_bs  = 1'b0;
    alu_fs  = 5'b11111;
    rf_b_en = 1'b0;
    rf_sa   = 5'd31;
    rf_sb   = 5'd31;
    rf_da   = 5'd31;
    rf_w    = 1'b0;
    ram_en  = 1'b0;
    ram_w   = 1'b0;
    pc_en   = 1'b0;
    pc_fs   = 2'b00;
    pc_is   = 1'b0;
    fetch   = 1'b0;

    case (phase_q)
      PH_FETCH: begin
        ram_en  = 1'b1;
        pc_fs   = FETCH_PC_FS;
        fetch   = 1'b1;
        i_d     = databus[31:0];
        state_d = 2'd0;
        phase_d = PH_EXEC;
      end

      PH_EXEC: begin
        alu_en  = cw_in[32];
        alu_bs  = cw_in[31];
        alu_fs  = cw_in[30:26];
        rf_b_en = cw_in[25];
        rf_sa   = cw_in[24:20];
        rf_sb   = cw_in[19:15];
        rf_da   = cw_in[14:10];
        rf_w    = cw_in[9];
        ram_en  = cw_in[8];
        ram_w   = cw_in[7];
        pc_en   = cw_in[6];
        pc_fs   = cw_in[5:4];
        pc_is   = cw_in[3];
        if (contention) begin
          // Block every state-changing write so the bad instruction leaves no trace.
          rf_w    = 1'b0;
          ram_w   = 1'b0;
          pc_fs   = 2'b00;
          fault_d = 1'b1;
          phase_d = PH_HALT;
        end else begin
          if (cw_status_ld) begin
            status_d = status_in;
          end
          if (cw_next_state == 2'd0) begin
            phase_d = PH_FETCH;
            state_d = 2'd0;
          end else begin
            state_d = cw_next_state;
          end
        end
      end

      PH_HALT: begin
        pc_fs = FETCH_PC_FS;
      end

      default: begin
        phase_d = PH_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_FETCH;
      i_q      <= 32'd0;
      state_q  <= 2'd0;
      status_q <= 5'd0;
      fault_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      i_q      <= i_d;
      state_q  <= state_d;
      status_q <= status_d;
      fault_q  <= fault_d;
    end
  end

  assign I      = i_q;
  assign state  = state_q;
  assign status = status_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_cw_sequencer.sv
// Scoreboard bench for cw_sequencer: directed scenarios then randomized control words,
// checked every cycle against a phase-level reference model.
module tb_cw_sequencer;

  localparam int P_FETCH = 0;
  localparam int P_EXEC  = 1;
  localparam int P_HALT  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] databus = '0;
  logic [32:0] cw_in = '0;
  logic [4:0]  status_in = '0;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is, fetch, fault;
  logic [4:0]  alu_fs, rf_sa, rf_sb, rf_da;
  logic [1:0]  pc_fs;

  cw_sequencer #(.FETCH_PC_FS(2'b01)) dut (
    .clock(clock), .reset(reset), .databus(databus), .cw_in(cw_in), .status_in(status_in),
    .I(I), .state(state), .status(status),
    .alu_en(alu_en), .alu_bs(alu_bs), .alu_fs(alu_fs), .rf_b_en(rf_b_en),
    .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_da(rf_da), .rf_w(rf_w),
    .ram_en(ram_en), .ram_w(ram_w), .pc_en(pc_en), .pc_fs(pc_fs), .pc_is(pc_is),
    .fetch(fetch), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] i;
    logic [1:0]  state;
    logic [4:0]  status;
    logic        fault;
    logic        fetch;
    logic        alu_en;
    logic        alu_bs;
    logic [4:0]  alu_fs;
    logic        rf_b_en;
    logic [4:0]  rf_sa;
    logic [4:0]  rf_sb;
    logic [4:0]  rf_da;
    logic        rf_w;
    logic        ram_en;
    logic        ram_w;
    logic        pc_en;
    logic [1:0]  pc_fs;
    logic        pc_is;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: architectural registers plus which phase the machine is in.
  int          m_phase  = P_FETCH;
  logic [31:0] m_i      = '0;
  logic [1:0]  m_state  = '0;
  logic [4:0]  m_status = '0;
  logic        m_fault  = 1'b0;

  task automatic drive(input logic rst, input logic [63:0] db,
                       input logic [32:0] cw, input logic [4:0] st);
    obs_t e;
    int   drivers;
    bit   clash;
    @(negedge clock);
    reset     = rst;
    databus   = db;
    cw_in     = cw;
    status_in = st;
    if (rst) begin
      m_phase = P_FETCH; m_i = '0; m_state = '0; m_status = '0; m_fault = 1'b0;
    end
    drivers = int'(cw[32]) + int'(cw[25]) + int'(cw[8]) + int'(cw[6]);
    clash   = (m_phase == P_EXEC) && (drivers > 1);

    e        = '0;
    e.i      = m_i;
    e.state  = m_state;
    e.status = m_status;
    e.fault  = m_fault;
    e.alu_fs = 5'd31;
    e.rf_sa  = 5'd31;
    e.rf_sb  = 5'd31;
    e.rf_da  = 5'd31;
    if (m_phase == P_FETCH) begin
      e.fetch = 1'b1; e.ram_en = 1'b1; e.pc_fs = 2'b01;
    end else if (m_phase == P_HALT) begin
      e.pc_fs = 2'b01;
    end else begin
      e.alu_en = cw[32];    e.alu_bs = cw[31];    e.alu_fs = cw[30:26];
      e.rf_b_en = cw[25];   e.rf_sa = cw[24:20];  e.rf_sb = cw[19:15];
      e.rf_da = cw[14:10];  e.rf_w = cw[9];       e.ram_en = cw[8];
      e.ram_w = cw[7];      e.pc_en = cw[6];      e.pc_fs = cw[5:4];
      e.pc_is = cw[3];
      if (clash) begin
        e.rf_w = 1'b0; e.ram_w = 1'b0; e.pc_fs = 2'b00;
      end
    end
    exp_q.push_back(e);

    if (!rst) begin
      if (m_phase == P_FETCH) begin
        m_i = db[31:0]; m_state = 2'd0; m_phase = P_EXEC;
      end else if (m_phase == P_EXEC) begin
        if (clash) begin
          m_fault = 1'b1; m_phase = P_HALT;
        end else begin
          if (cw[2]) m_status = st;
          if (cw[1:0] == 2'd0) begin
            m_phase = P_FETCH; m_state = 2'd0;
          end else begin
            m_state = cw[1:0];
          end
        end
      end
    end
  endtask

  function automatic logic [32:0] rand_cw(input bit force_clash);
    logic [63:0] r;
    logic [32:0] c;
    int k;
    r = {$urandom, $urandom};
    c = r[32:0];
    c[32] = 1'b0; c[25] = 1'b0; c[8] = 1'b0; c[6] = 1'b0;
    k = $urandom_range(0, 4);
    case (k)
      0: c[32] = 1'b1;
      1: c[25] = 1'b1;
      2: c[8]  = 1'b1;
      3: c[6]  = 1'b1;
      default: ;
    endcase
    if (force_clash) begin
      c[32] = 1'b1; c[8] = 1'b1;
    end
    return c;
  endfunction

  // Monitor: one observation per cycle, mid low phase, well clear of the rising edge.
  obs_t mon_e, mon_a;
  initial begin
    forever begin
      @(negedge clock);
      #3;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a.i = I; mon_a.state = state; mon_a.status = status; mon_a.fault = fault;
        mon_a.fetch = fetch; mon_a.alu_en = alu_en; mon_a.alu_bs = alu_bs;
        mon_a.alu_fs = alu_fs; mon_a.rf_b_en = rf_b_en; mon_a.rf_sa = rf_sa;
        mon_a.rf_sb = rf_sb; mon_a.rf_da = rf_da; mon_a.rf_w = rf_w;
        mon_a.ram_en = ram_en; mon_a.ram_w = ram_w; mon_a.pc_en = pc_en;
        mon_a.pc_fs = pc_fs; mon_a.pc_is = pc_is;
        n_cmp++;
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL outputs cycle=%0d got=%h expected=%h (I=%h state=%0d status=%b fault=%b fetch=%b)",
                   cyc, mon_a, mon_e, I, state, status, fault, fetch);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] c;
    int halt_cycles;

    drive(1'b1, '0, '0, '0);
    drive(1'b1, '0, '0, '0);

    // Fetch of 0x94000005 right after reset release.
    drive(1'b0, {32'hDEADBEEF, 32'h94000005}, rand_cw(1'b1), 5'd0);
    // Two-cycle execute: first loads status and moves to state 1.
    c = rand_cw(1'b0); c[32] = 1'b1; c[25] = 1'b0; c[8] = 1'b0; c[6] = 1'b0;
    c[2] = 1'b1; c[1:0] = 2'b01;
    drive(1'b0, {$urandom, $urandom}, c, 5'b10101);
    c = rand_cw(1'b0); c[2] = 1'b0; c[1:0] = 2'b00;
    drive(1'b0, {$urandom, $urandom}, c, 5'b01010);
    drive(1'b0, {32'h0, 32'h12345678}, rand_cw(1'b0), 5'd0);
    // Single driver (PC only) with register write to r30 passes straight through.
    c = rand_cw(1'b0); c[32] = 1'b0; c[25] = 1'b0; c[8] = 1'b0; c[6] = 1'b1;
    c[9] = 1'b1; c[14:10] = 5'd30; c[1:0] = 2'b01;
    drive(1'b0, {$urandom, $urandom}, c, 5'd3);
    // Reset while in state 1 of a multi-cycle execute.
    drive(1'b1, {$urandom, $urandom}, rand_cw(1'b0), 5'd7);
    drive(1'b1, {$urandom, $urandom}, rand_cw(1'b0), 5'd7);
    drive(1'b0, {32'h0, 32'hCAFEF00D}, rand_cw(1'b0), 5'd0);
    // ALU and RAM both driving the bus, with a register write pending.
    c = rand_cw(1'b1); c[9] = 1'b1; c[7] = 1'b1; c[5:4] = 2'b11; c[2] = 1'b1;
    drive(1'b0, {$urandom, $urandom}, c, 5'b11111);
    for (int n = 0; n < 4; n++) drive(1'b0, {$urandom, $urandom}, rand_cw(1'b0), 5'(n));
    drive(1'b1, '0, '0, '0);

    halt_cycles = 0;
    for (int n = 0; n < 800; n++) begin
      if (m_phase == P_HALT) halt_cycles++;
      if ((halt_cycles > 4) || ($urandom_range(0, 99) == 0)) begin
        halt_cycles = 0;
        drive(1'b1, {$urandom, $urandom}, rand_cw(1'b0), 5'($urandom));
      end else begin
        drive(1'b0, {$urandom, $urandom}, rand_cw($urandom_range(0, 29) == 0),
              5'($urandom));
      end
    end

    @(negedge clock);
    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
